dct_result_collector: RTL and testbench

DCT_RESULT_COLLECTOR -- requirements
Module: dct_result_collector

---
 rtl/dct_result_collector_if.sv | 32 +++
 rtl/dct_result_collector.sv | 186 ++++++++++++++++++
 tb/tb_dct_result_collector.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/dct_result_collector_if.sv
// Result bus between the DCT control FSM / downstream consumer and the
// collector. Carries the result-capture inputs, the drain handshake and the
// status outputs. Clock and reset stay plain ports on the collector.
interface dct_result_collector_if #(
    parameter int DATA_W = 16
);
    logic              ready_in;
    logic [2:0]        x_in;
    logic [2:0]        y_in;
    logic [DATA_W-1:0] data_in;
    logic              out_ack;

    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [5:0]        out_index;
    logic [5:0]        out_pos;
    logic              busy;
    logic              block_done;
    logic              overflow;

    // Collector side: captures results and offers the scanned block.
    modport slave (
        input  ready_in, x_in, y_in, data_in, out_ack,
        output out_valid, out_data, out_index, out_pos, busy, block_done, overflow
    );

    // Environment side: produces results and consumes the scanned block.
    modport master (
        output ready_in, x_in, y_in, data_in, out_ack,
        input  out_valid, out_data, out_index, out_pos, busy, block_done, overflow
    );
endinterface

// File: rtl/dct_result_collector.sv
// DCT result collector: gathers 64 results of an 8x8 block into a local
// buffer (addressed by raster position {row,col}), then offers them one per
// accepted handshake in scan order.
//
// Build option: define DCT_ZIGZAG_EN to scan in MPEG 8x8 zigzag order from a
// constant table; left undefined, the scan is raster order and out_pos always
// equals out_index.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// COLLECT | accepting results into the buffer, counting pulses up to 64
// LOAD    | one cycle: register the first scanned sample, raise out_valid
// DRAIN   | offering samples; each ack advances the scan, last ack ends block
module dct_result_collector #(
    parameter int DATA_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_in,
    dct_result_collector_if.slave   bus
);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_LOAD    = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

`ifdef DCT_ZIGZAG_EN
    localparam logic [5:0] C_ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };
`endif

    // Scan position -> raster address.
    function automatic logic [5:0] f_order(input logic [5:0] i);
`ifdef DCT_ZIGZAG_EN
        return C_ZZ[i];
`else
        return i;
`endif
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;

    logic [DATA_W-1:0] r_buf [64];
    logic [6:0]        r_cnt;
    logic [5:0]        r_idx;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [5:0]        r_out_index;
    logic [5:0]        r_out_pos;
    logic              r_block_done;
    logic              r_overflow;

    logic              w_buf_we;
    logic              w_load;
    logic              w_advance;
    logic              w_finish;
    logic              w_ovf_set;
    logic [5:0]        w_wr_addr;
    logic [5:0]        w_idx_nxt;
    logic [5:0]        w_rd_idx;
    logic [5:0]        w_rd_addr;

    assign w_wr_addr = {bus.y_in, bus.x_in};
    assign w_idx_nxt = r_idx + 6'd1;
    assign w_rd_addr = f_order(w_rd_idx);

    // State register.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath strobes. A result arriving outside COLLECT is
    // dropped and flagged, including on the edge of the final ack.
    always_comb begin
        w_state_nxt = r_state;
        w_buf_we    = 1'b0;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        w_finish    = 1'b0;
        w_ovf_set   = 1'b0;
        w_rd_idx    = w_idx_nxt;
        case (r_state)
            S_COLLECT: begin
                if (bus.ready_in) begin
                    w_buf_we = 1'b1;
                    if (r_cnt == 7'd63) begin
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                w_load      = 1'b1;
                w_rd_idx    = 6'd0;
                w_ovf_set   = bus.ready_in;
                w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                w_ovf_set = bus.ready_in;
                if (r_out_valid && bus.out_ack) begin
                    if (r_idx == 6'd63) begin
                        w_finish    = 1'b1;
                        w_state_nxt = S_COLLECT;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_COLLECT;
            end
        endcase
    end

    // Sample buffer; contents are not reset, a block is only offered after a
    // fresh set of 64 results.
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buf[w_wr_addr] <= bus.data_in;
        end
    end

    // Counters, output sample register and status flags.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            r_cnt        <= 7'd0;
            r_idx        <= 6'd0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_index  <= 6'd0;
            r_out_pos    <= 6'd0;
            r_block_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_block_done <= 1'b0;
            if (w_buf_we) begin
                r_cnt <= r_cnt + 7'd1;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
            if (w_load) begin
                r_out_data  <= r_buf[w_rd_addr];
                r_out_index <= 6'd0;
                r_out_pos   <= w_rd_addr;
                r_out_valid <= 1'b1;
                r_idx       <= 6'd0;
            end
            if (w_advance) begin
                r_out_data  <= r_buf[w_rd_addr];
                r_out_index <= w_idx_nxt;
                r_out_pos   <= w_rd_addr;
                r_idx       <= w_idx_nxt;
            end
            if (w_finish) begin
                r_out_valid  <= 1'b0;
                r_block_done <= 1'b1;
                r_cnt        <= 7'd0;
                r_idx        <= 6'd0;
            end
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_index  = r_out_index;
    assign bus.out_pos    = r_out_pos;
    assign bus.busy       = (r_state != S_COLLECT);
    assign bus.block_done = r_block_done;
    assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_dct_result_collector.sv
// Bench for dct_result_collector: directed scenarios plus randomized blocks,
// checked against a buffer/scan-order reference model.
module tb_dct_result_collector;

    logic clk;
    logic rst_in;

    dct_result_collector_if #(.DATA_W(16)) bus_if ();

    dct_result_collector #(.DATA_W(16)) dut (
        .clk    (clk),
        .rst_in (rst_in),
        .bus    (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_assert;
    int          n_fail;
    logic [15:0] model_buf [64];
    bit          model_wr  [64];
    bit          model_ovf;

    // Scan position -> raster address, derived by walking the anti-diagonals.
    function automatic int order_ref(input int i);
`ifdef DCT_ZIGZAG_EN
        int n;
        n = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 7 ? s : 7); r >= 0 && r >= s - 7; r--) begin
                    if (n == i) return r * 8 + (s - r);
                    n++;
                end
            end else begin
                for (int r = (s < 7 ? 0 : s - 7); r <= 7 && r <= s; r++) begin
                    if (n == i) return r * 8 + (s - r);
                    n++;
                end
            end
        end
        return -1;
`else
        return i;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_block();
        for (int i = 0; i < 64; i++) model_wr[i] = 1'b0;
    endtask

    // One result pulse; called and returns at a falling edge.
    task automatic send(input int x, input int y, input logic [15:0] d);
        bus_if.ready_in = 1'b1;
        bus_if.x_in     = 3'(x);
        bus_if.y_in     = 3'(y);
        bus_if.data_in  = d;
        @(posedge clk);
        @(negedge clk);
        bus_if.ready_in = 1'b0;
        model_buf[y * 8 + x] = d;
        model_wr[y * 8 + x]  = 1'b1;
    endtask

    // Called at the falling edge right after the 64th result was captured.
    task automatic drain(input int stall_idx, input int stall_len, input bit rand_ack,
                         input int inject_idx);
        int k;
        int stalls;
        int cycles;
        bit ack;
        bit injected;
        k = 0; stalls = 0; cycles = 0; injected = 1'b0;
        check("lat_valid_low", 32'(bus_if.out_valid), 32'd0);
        check("lat_busy", 32'(bus_if.busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("lat_valid_high", 32'(bus_if.out_valid), 32'd1);
        while (k < 64 && cycles < 2000) begin
            cycles++;
            check("drain_valid", 32'(bus_if.out_valid), 32'd1);
            check("drain_index", 32'(bus_if.out_index), 32'(k));
            check("drain_pos", 32'(bus_if.out_pos), 32'(order_ref(k)));
            if (model_wr[order_ref(k)])
                check("drain_data", 32'(bus_if.out_data), 32'(model_buf[order_ref(k)]));
            ack = 1'b1;
            if (k == stall_idx && stalls < stall_len) begin
                ack = 1'b0;
                stalls++;
            end else if (rand_ack && $urandom_range(0, 2) == 0) begin
                ack = 1'b0;
            end
            bus_if.out_ack = ack;
            if (k == inject_idx && ack && !injected) begin
                bus_if.ready_in = 1'b1;
                bus_if.x_in     = 3'($urandom_range(0, 7));
                bus_if.y_in     = 3'($urandom_range(0, 7));
                bus_if.data_in  = 16'hBEEF;
                model_ovf       = 1'b1;
                injected        = 1'b1;
            end
            @(posedge clk);
            if (ack) k++;
            @(negedge clk);
            bus_if.ready_in = 1'b0;
            if (k < 64) check("drain_no_done", 32'(bus_if.block_done), 32'd0);
        end
        bus_if.out_ack = 1'b0;
        check("drain_budget", 32'(k), 32'd64);
        if (!rand_ack) check("drain_cycles", 32'(cycles), 32'(64 + stall_len));
        check("done_pulse", 32'(bus_if.block_done), 32'd1);
        check("done_valid_low", 32'(bus_if.out_valid), 32'd0);
        check("done_busy_low", 32'(bus_if.busy), 32'd0);
        check("done_overflow", 32'(bus_if.overflow), 32'(model_ovf));
        @(negedge clk);
        check("done_one_cycle", 32'(bus_if.block_done), 32'd0);
    endtask

    task automatic send_raster(input bit data_is_addr);
        start_block();
        for (int p = 0; p < 64; p++)
            send(p % 8, p / 8, data_is_addr ? 16'(p) : 16'($urandom()));
    endtask

    int perm [64];

    initial begin
        n_assert = 0;
        n_fail   = 0;
        model_ovf = 1'b0;
        bus_if.ready_in = 1'b0;
        bus_if.x_in     = 3'd0;
        bus_if.y_in     = 3'd0;
        bus_if.data_in  = 16'd0;
        bus_if.out_ack  = 1'b0;
        rst_in = 1'b0;
        #1;
        check("rst_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_data", 32'(bus_if.out_data), 32'd0);
        check("rst_index", 32'(bus_if.out_index), 32'd0);
        check("rst_pos", 32'(bus_if.out_pos), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_done", 32'(bus_if.block_done), 32'd0);
        check("rst_overflow", 32'(bus_if.overflow), 32'd0);
        @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);

        // Raster data, ack held high throughout (also while nothing is valid).
        bus_if.out_ack = 1'b1;
        send_raster(1'b1);
        drain(-1, 0, 1'b0, -1);

        // Downstream stall of five cycles at scan index 10.
        send_raster(1'b0);
        drain(10, 5, 1'b0, -1);

        // Result arriving during drain is dropped and flagged.
        send_raster(1'b0);
        drain(-1, 0, 1'b0, 20);
        check("ovf_sticky", 32'(bus_if.overflow), 32'd1);
        send_raster(1'b0);
        drain(-1, 0, 1'b0, -1);

        // Reset part-way through a block: only the fresh block is drained.
        start_block();
        for (int p = 0; p < 30; p++) send(p % 8, p / 8, 16'($urandom()));
        rst_in = 1'b0;
        #1;
        model_ovf = 1'b0;
        check("mid_rst_busy", 32'(bus_if.busy), 32'd0);
        check("mid_rst_overflow", 32'(bus_if.overflow), 32'd0);
        check("mid_rst_valid", 32'(bus_if.out_valid), 32'd0);
        @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);
        send_raster(1'b0);
        drain(-1, 0, 1'b0, -1);

        // Repeated address (3,4): last write wins, every pulse counts.
        start_block();
        send(4, 3, 16'h0011);
        begin
            int sent;
            sent = 1;
            for (int p = 0; p < 64; p++) begin
                if (p == 5 || p == 28) continue;
                if (sent == 30) begin
                    send(4, 3, 16'h0022);
                    sent++;
                end
                if (sent == 63) begin
                    check("dup_busy_before_last", 32'(bus_if.busy), 32'd0);
                    check("dup_valid_before_last", 32'(bus_if.out_valid), 32'd0);
                end
                send(p % 8, p / 8, 16'($urandom()));
                sent++;
            end
            check("dup_pulses", 32'(sent), 32'd64);
        end
        check("dup_model_28", 32'(model_buf[28]), 32'h0022);
        drain(-1, 0, 1'b0, -1);

        // Randomized blocks: shuffled addresses, idle gaps, random ack.
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 64; i++) perm[i] = i;
            for (int i = 63; i > 0; i--) begin
                int j;
                int t;
                j = int'($urandom_range(0, i));
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
            start_block();
            for (int i = 0; i < 64; i++) begin
                if (i != 63 && $urandom_range(0, 3) == 0) @(negedge clk);
                send(perm[i] % 8, perm[i] / 8, 16'($urandom()));
            end
            drain(-1, 0, 1'b1, (b == 2) ? 63 : -1);
        end
        check("final_overflow", 32'(bus_if.overflow), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
